id_operand_scoreboard: RTL and testbench
========================================

Name: id_operand_scoreboard

Overview:
- Operand-supply and hazard unit for the decode stage, and the parametrised successor of fixed EX/MEM two-source forwarding.
- Keeps a shift-register scoreboard of in-flight register writes, one slot per downstream pipeline stage (slot 0 = EX).
- Forwards the youngest matching result to NUM_RD operand ports.
- Raises stall when a matching producer's data is not yet available (load-use, multi-cycle ops). Never forwards $0.

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register address width
NUM_RD, 2, number of operand read ports
DEPTH, 3, number of tracked downstream stages (EX..WB); minimum 2
RS_W, $clog2(DEPTH), width of ready-stage field (derived, not overridden)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
issue_valid_i  in  1  decode holds a valid instruction this cycle
wreg_i  in  1  issuing instruction writes a register
wd_i  in  ADDR_W  destination of issuing instruction
rdy_stage_i  in  RS_W  first slot at which its result is valid (0 = end of EX)
rd_en_i  in  NUM_RD  per-port read enable
rd_addr_i  in  NUM_RD*ADDR_W  per-port register address, port k at [k*ADDR_W +: ADDR_W]
rf_data_i  in  NUM_RD*DATA_W  regfile read data per port
stage_wdata_i  in  DEPTH*DATA_W  result data currently held in slot p's stage
hold_i  in  1  downstream freeze; scoreboard does not shift
flush_i  in  1  squash all in-flight entries
operand_o  out  NUM_RD*DATA_W  resolved operand per port
stall_o  out  1  decode must stall (data hazard)
stall_cnt_o  out  32  saturating count of stall cycles

Behaviour:
- Slot contents: valid, wd, rdy (RS_W bits).
- Reset (async, rst=1):
  - All slots invalid; stall_cnt_o = 0.
  - Combinational outputs forced: operand_o = 0, stall_o = 0, while rst is high.
- Per port k (combinational, same cycle as decode):
  - rd_en=0 or addr=0 -> operand 0, no hazard.
  - Otherwise scan slots 0..DEPTH-1; the first valid slot with wd==addr wins (youngest).
    - Hit at p with p >= rdy -> operand = stage_wdata_i[p].
    - Hit at p with p < rdy -> hazard_k = 1; operand = rf_data_i (don't-care, but defined).
    - No hit -> operand = rf_data_i[k].
- stall_o = issue_valid_i & OR(hazard_k). Entries at p < rdy never fall through to an older slot.
- Clock edge, in priority order:
  - flush_i=1 -> all slots invalid (flush beats hold).
  - else hold_i=1 -> slots unchanged.
  - else slot[p] <= slot[p-1] for p >= 1. slot[0] <= {1, wd_i, clamp(rdy_stage_i)} if issue_valid_i & wreg_i & wd_i != 0 & !stall_o; otherwise invalid (bubble).
  - Oldest slot is discarded on shift; the regfile must hold its value by then.
- rdy_stage_i >= DEPTH is clamped to DEPTH-1.
- Latency:
  - An issued write is visible to the next decode cycle at slot 0.
  - A load with rdy=1 stalls exactly one cycle.
  - A producer with rdy=r stalls a dependent issued in the following cycle for r cycles.
- stall_cnt_o increments on each edge with stall_o=1 and hold_i=0; it saturates at all-ones and is not cleared by flush.
- Writes to $0 are never tracked.

Decomposition:
- Shared package (defines file): RstEnable, WriteEnable, ReadEnable, ZeroWord, NOPRegAddr, and the scoreboard entry field widths.
- One natural sub-module, sb_port_lookup: per-port priority match plus mux. It takes the slot array, stage data, address and enable, and returns operand and hazard. Instantiate it NUM_RD times via generate.

Test Plan:
- ALU back-to-back:
  - Stimulus: issue wreg $1 rdy=0; next cycle read port0 $1, stage_wdata[0]=0x00001234.
  - Required: operand0=0x00001234, stall_o=0.
- Load-use:
  - Stimulus: issue $2 rdy=1; next cycle read $2.
  - Required: stall_o=1 and stall_cnt=1 after the edge. Following cycle the entry is at slot1 with stage_wdata[1]=0xDEADBEEF: operand=0xDEADBEEF, stall_o=0, slot0 bubble.
- Youngest wins:
  - Stimulus: $3 at slot0 (0x0000000A) and slot1 (0x0000000B), both ready; ports 0 and 1 both read $3.
  - Required: both operands = 0x0000000A.
- $0 and disabled port:
  - Stimulus: issue wreg $0; next cycle read $0 with rf_data=0x55555555; port1 rd_en=0.
  - Required: operand0=0, operand1=0, no slot allocated.
- Flush/hold:
  - Stimulus: $4 at slot0, hold_i=1 for 2 cycles.
  - Required: still forwarded from slot0. Then flush_i=1 with hold_i=1: next cycle read $4 returns rf_data_i=0x00000044.
- Async reset mid-stall:
  - Stimulus: assert rst between edges while stall_o=1.
  - Required: stall_o=0, operand_o=0 immediately; after release all slots invalid, stall_cnt_o=0.

Source files
------------

// File: rtl/id_operand_scoreboard_pkg.sv
// Shared constants and helpers for the decode-stage operand scoreboard.
// The scoreboard entry field widths are here. The ready-stage clamp helper is also here.
package id_operand_scoreboard_pkg;

  localparam logic        RstEnable   = 1'b1;
  localparam logic        WriteEnable = 1'b1;
  localparam logic        ReadEnable  = 1'b1;
  localparam logic [31:0] ZeroWord    = 32'h0000_0000;
  localparam logic [4:0]  NOPRegAddr  = 5'd0;

  // Scoreboard entry layout: {valid, wd[ADDR_W], rdy[RS_W]}
  localparam int SB_VALID_W = 1;

  function automatic int unsigned sb_rs_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // A ready stage past the last tracked slot is treated as the last slot.
  function automatic int unsigned sb_clamp_rdy(input int unsigned rdy, input int unsigned depth);
    return (rdy >= depth) ? depth - 1 : rdy;
  endfunction

endpackage

// File: rtl/id_operand_scoreboard_port_lookup.sv
// Per-port lookup. It finds the youngest matching in-flight write.
// It then either forwards that write's stage data or flags a hazard.
module sb_port_lookup
  import id_operand_scoreboard_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 3,
  parameter int RS_W   = 2
) (
  input  logic                    i_en,
  input  logic [ADDR_W-1:0]       i_addr,
  input  logic [DATA_W-1:0]       i_rf_data,
  input  logic [DEPTH-1:0]        i_slot_valid,
  input  logic [DEPTH*ADDR_W-1:0] i_slot_wd,
  input  logic [DEPTH*RS_W-1:0]   i_slot_rdy,
  input  logic [DEPTH*DATA_W-1:0] i_stage_wdata,
  output logic [DATA_W-1:0]       o_operand,
  output logic                    o_hazard
);

  logic w_hit;

  always_comb begin
    o_operand = i_rf_data;
    o_hazard  = 1'b0;
    w_hit     = 1'b0;
    if (i_en != ReadEnable || i_addr == ADDR_W'(NOPRegAddr)) begin
      o_operand = DATA_W'(ZeroWord);
    end else begin
      // The first match stops the scan, so a not-ready young entry is never bypassed.
      for (int p = 0; p < DEPTH; p++) begin
        if (!w_hit && i_slot_valid[p] && i_slot_wd[p*ADDR_W +: ADDR_W] == i_addr) begin
          w_hit = 1'b1;
          if (RS_W'(p) >= i_slot_rdy[p*RS_W +: RS_W])
            o_operand = i_stage_wdata[p*DATA_W +: DATA_W];
          else
            o_hazard = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/id_operand_scoreboard.sv
// This is the decode-stage operand supply and hazard unit.
// It keeps a shift-register scoreboard of in-flight writes, with slot 0 at EX.
module id_operand_scoreboard
  import id_operand_scoreboard_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int DEPTH  = 3,
  localparam int RS_W  = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_valid_i,
  input  logic                     wreg_i,
  input  logic [ADDR_W-1:0]        wd_i,
  input  logic [RS_W-1:0]          rdy_stage_i,
  input  logic [NUM_RD-1:0]        rd_en_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  input  logic [NUM_RD*DATA_W-1:0] rf_data_i,
  input  logic [DEPTH*DATA_W-1:0]  stage_wdata_i,
  input  logic                     hold_i,
  input  logic                     flush_i,
  output logic [NUM_RD*DATA_W-1:0] operand_o,
  output logic                     stall_o,
  output logic [31:0]              stall_cnt_o
);

  logic [DEPTH-1:0]        r_valid;
  logic [DEPTH*ADDR_W-1:0] r_wd;
  logic [DEPTH*RS_W-1:0]   r_rdy;
  logic [31:0]             r_stall_cnt;

  logic [NUM_RD-1:0]        w_hazard;
  logic [NUM_RD*DATA_W-1:0] w_operand;
  logic                     w_stall;
  logic                     w_alloc;
  logic [RS_W-1:0]          w_rdy_clamped;

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_port
    sb_port_lookup #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W),
      .DEPTH (DEPTH),
      .RS_W  (RS_W)
    ) u_lookup (
      .i_en         (rd_en_i[gi]),
      .i_addr       (rd_addr_i[gi*ADDR_W +: ADDR_W]),
      .i_rf_data    (rf_data_i[gi*DATA_W +: DATA_W]),
      .i_slot_valid (r_valid),
      .i_slot_wd    (r_wd),
      .i_slot_rdy   (r_rdy),
      .i_stage_wdata(stage_wdata_i),
      .o_operand    (w_operand[gi*DATA_W +: DATA_W]),
      .o_hazard     (w_hazard[gi])
    );
  end

  assign w_stall       = issue_valid_i & (|w_hazard);
  assign w_rdy_clamped = RS_W'(sb_clamp_rdy(32'(rdy_stage_i), DEPTH));
  assign w_alloc       = issue_valid_i & (wreg_i == WriteEnable)
                       & (wd_i != ADDR_W'(NOPRegAddr)) & ~w_stall;

  assign stall_o     = (rst == RstEnable) ? 1'b0 : w_stall;
  assign operand_o   = (rst == RstEnable) ? '0 : w_operand;
  assign stall_cnt_o = r_stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      r_valid     <= '0;
      r_wd        <= '0;
      r_rdy       <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (flush_i) begin
        r_valid <= '0;
      end else if (!hold_i) begin
        // A stalled or non-writing issue shifts a bubble into EX.
        r_valid <= {r_valid[DEPTH-2:0], w_alloc};
        r_wd    <= {r_wd[(DEPTH-1)*ADDR_W-1:0], wd_i};
        r_rdy   <= {r_rdy[(DEPTH-1)*RS_W-1:0], w_rdy_clamped};
      end
      if (w_stall && !hold_i && r_stall_cnt != '1)
        r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_id_operand_scoreboard.sv
// Directed bench for id_operand_scoreboard with hand-computed expectations.
module tb_id_operand_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid_i;
  logic        wreg_i;
  logic [4:0]  wd_i;
  logic [1:0]  rdy_stage_i;
  logic [1:0]  rd_en_i;
  logic [9:0]  rd_addr_i;
  logic [63:0] rf_data_i;
  logic [95:0] stage_wdata_i;
  logic        hold_i;
  logic        flush_i;
  logic [63:0] operand_o;
  logic        stall_o;
  logic [31:0] stall_cnt_o;

  int test_cnt = 0;
  int fail_cnt = 0;

  always #5 clk = ~clk;

  id_operand_scoreboard dut (
    .clk          (clk),
    .rst          (rst),
    .issue_valid_i(issue_valid_i),
    .wreg_i       (wreg_i),
    .wd_i         (wd_i),
    .rdy_stage_i  (rdy_stage_i),
    .rd_en_i      (rd_en_i),
    .rd_addr_i    (rd_addr_i),
    .rf_data_i    (rf_data_i),
    .stage_wdata_i(stage_wdata_i),
    .hold_i       (hold_i),
    .flush_i      (flush_i),
    .operand_o    (operand_o),
    .stall_o      (stall_o),
    .stall_cnt_o  (stall_cnt_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    test_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("[TB] check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic idle();
    issue_valid_i = 1'b0; wreg_i = 1'b0; wd_i = 5'd0; rdy_stage_i = 2'd0;
    rd_en_i = 2'b00; rd_addr_i = '0; rf_data_i = '0; stage_wdata_i = '0;
    hold_i = 1'b0; flush_i = 1'b0;
  endtask

  task automatic issue(input logic [4:0] wd, input logic [1:0] rdy);
    idle();
    issue_valid_i = 1'b1; wreg_i = 1'b1; wd_i = wd; rdy_stage_i = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #2;
    // reset state
    rd_en_i = 2'b01; rd_addr_i = {5'd0, 5'd9}; rf_data_i = {32'h0, 32'h9999_9999};
    #1;
    check("rst_operand", operand_o, 64'h0);
    check("rst_stall", {63'h0, stall_o}, 64'h0);
    step();
    rst = 1'b0;
    idle();
    #1;
    check("rst_cnt", {32'h0, stall_cnt_o}, 64'h0);

    // ALU back-to-back
    issue(5'd1, 2'd0); #1;
    check("alu_issue_stall", {63'h0, stall_o}, 64'h0);
    step();
    idle(); issue_valid_i = 1'b1;
    rd_en_i = 2'b01; rd_addr_i = {5'd0, 5'd1};
    rf_data_i = {32'h0, 32'h0000_9999}; stage_wdata_i[31:0] = 32'h0000_1234; #1;
    check("alu_fwd_op0", {32'h0, operand_o[31:0]}, 64'h1234);
    check("alu_fwd_stall", {63'h0, stall_o}, 64'h0);
    step();

    // Load-use: dependent also writes $5 but must not allocate while stalled
    issue(5'd2, 2'd1); #1;
    step();
    issue(5'd5, 2'd0);
    rd_en_i = 2'b01; rd_addr_i = {5'd0, 5'd2};
    rf_data_i = {32'h0, 32'h0000_1111}; stage_wdata_i[31:0] = 32'h0000_BAD0; #1;
    check("lu_stall", {63'h0, stall_o}, 64'h1);
    check("lu_op0_rf", {32'h0, operand_o[31:0]}, 64'h1111);
    step();
    check("lu_cnt1", {32'h0, stall_cnt_o}, 64'h1);
    rd_en_i = 2'b11; rd_addr_i = {5'd5, 5'd2};
    rf_data_i = {32'h0000_5555, 32'h0000_1111};
    stage_wdata_i = {32'h0, 32'hDEAD_BEEF, 32'h0000_AAAA}; #1;
    check("lu_fwd_slot1", {32'h0, operand_o[31:0]}, 64'hDEAD_BEEF);
    check("lu_nostall", {63'h0, stall_o}, 64'h0);
    check("lu_slot0_bubble", {32'h0, operand_o[63:32]}, 64'h5555);
    step();
    check("lu_cnt_hold1", {32'h0, stall_cnt_o}, 64'h1);

    // Youngest wins
    issue(5'd3, 2'd0); step();
    issue(5'd3, 2'd0); step();
    idle();
    rd_en_i = 2'b11; rd_addr_i = {5'd3, 5'd3};
    rf_data_i = {32'h0000_0033, 32'h0000_0033};
    stage_wdata_i = {32'h0000_000C, 32'h0000_000B, 32'h0000_000A}; #1;
    check("yw_op0", {32'h0, operand_o[31:0]}, 64'hA);
    check("yw_op1", {32'h0, operand_o[63:32]}, 64'hA);
    step();

    // rdy=3 clamps to slot 2: dependent stalls exactly two cycles
    issue(5'd6, 2'd3); step();
    idle(); issue_valid_i = 1'b1;
    rd_en_i = 2'b01; rd_addr_i = {5'd0, 5'd6};
    rf_data_i = {32'h0, 32'h0000_0066}; stage_wdata_i = {32'h0000_6600, 64'h0}; #1;
    check("clamp_stall_s0", {63'h0, stall_o}, 64'h1);
    step();
    check("clamp_stall_s1", {63'h0, stall_o}, 64'h1);
    step();
    check("clamp_nostall_s2", {63'h0, stall_o}, 64'h0);
    check("clamp_fwd_s2", {32'h0, operand_o[31:0]}, 64'h6600);
    check("clamp_cnt3", {32'h0, stall_cnt_o}, 64'h3);
    step();

    // $0 and disabled port
    issue(5'd0, 2'd1); step();
    idle(); issue_valid_i = 1'b1;
    rd_en_i = 2'b01; rd_addr_i = {5'd4, 5'd0};
    rf_data_i = {32'h1234_5678, 32'h5555_5555}; stage_wdata_i = {3{32'h7777_7777}}; #1;
    check("zero_op0", {32'h0, operand_o[31:0]}, 64'h0);
    check("zero_op1_dis", {32'h0, operand_o[63:32]}, 64'h0);
    check("zero_nostall", {63'h0, stall_o}, 64'h0);
    step();

    // Hold freezes, flush beats hold
    issue(5'd4, 2'd0); step();
    for (int c = 0; c < 3; c++) begin
      idle(); hold_i = 1'b1; flush_i = (c == 2);
      rd_en_i = 2'b01; rd_addr_i = {5'd0, 5'd4};
      rf_data_i = {32'h0, 32'h0000_0044}; stage_wdata_i[31:0] = 32'h0000_4444; #1;
      check($sformatf("hold_fwd_c%0d", c), {32'h0, operand_o[31:0]}, 64'h4444);
      step();
    end
    hold_i = 1'b0; flush_i = 1'b0; #1;
    check("flush_rf", {32'h0, operand_o[31:0]}, 64'h44);

    // Held stall does not count; async reset mid-stall
    step();
    issue(5'd7, 2'd2); step();
    idle(); issue_valid_i = 1'b1; hold_i = 1'b1;
    rd_en_i = 2'b01; rd_addr_i = {5'd0, 5'd7}; rf_data_i = {32'h0, 32'h0000_0077}; #1;
    check("hs_stall", {63'h0, stall_o}, 64'h1);
    step();
    check("hs_cnt_nohold_inc", {32'h0, stall_cnt_o}, 64'h3);
    hold_i = 1'b0; #1;
    check("hs_stall_still", {63'h0, stall_o}, 64'h1);
    check("hs_op_rf", {32'h0, operand_o[31:0]}, 64'h77);
    rst = 1'b1; #1;
    check("ar_stall", {63'h0, stall_o}, 64'h0);
    check("ar_operand", operand_o, 64'h0);
    check("ar_cnt", {32'h0, stall_cnt_o}, 64'h0);
    step();
    rst = 1'b0; #1;
    check("ar_post_nostall", {63'h0, stall_o}, 64'h0);
    check("ar_post_rf", {32'h0, operand_o[31:0]}, 64'h77);
    step();
    check("ar_post_cnt", {32'h0, stall_cnt_o}, 64'h0);

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
